// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the serial XOR cipher transmit and receive paths.
// Provides default frame/key sizes, the bit-counter width helper and the frame FSM states.
// No logic; consumed via import xor_cipher_pkg::*.
package xor_cipher_pkg;

    localparam int KEY_SIZE_DEF = 32;
    localparam int MSG_SIZE_DEF = 512;

    // Bit counter must be able to hold MSG_SIZE itself, hence the extra bit.
    function automatic int bit_cnt_w(input int msg_size);
        return $clog2(msg_size) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } xor_state_e;

endpackage

// File: rtl/xor_byte_fifo.sv
// Byte FIFO between the decrypt packer and the byte consumer (DEPTH power of two, >= 2).
// Latency: a pushed byte is visible at rd_dat the cycle after the push edge.
// Backpressure: rd_rdy stalls the head; a push while full with no pop is dropped and flagged on wr_drop.
// Ports: wr_vld/wr_dat push side, wr_drop drop indication, rd_vld/rd_rdy/rd_dat pop side.
module xor_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       core_clk,
    input  logic       arst_n,
    input  logic       wr_vld,
    input  logic [7:0] wr_dat,
    output logic       wr_drop,
    output logic       rd_vld,
    input  logic       rd_rdy,
    output logic [7:0] rd_dat
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop     = rd_rdy && !empty;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push    = wr_vld && (!full || pop);
    assign wr_drop = wr_vld && !push;
    assign rd_vld  = !empty;
    assign rd_dat  = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_q    <= '{default: 8'h00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/xor_stream_decrypt.sv
// Receive-side XOR stream decrypt: framed 1-bit ciphertext in, plaintext bytes out through a small FIFO.
// Latency: 2 cycles from the byte's last stream bit to oData_valid when the FIFO is empty.
// Backpressure: none on the stream; iData_ready stalls the FIFO head and excess bytes are dropped (oOverflow).
// Ports: iClk/iRst_n/iEn control, iKey/iKey_load key, iSerial_* framed stream, oData/oData_valid/iData_ready
//        byte output, oFrame_done/oFrame_err pulses, oOverflow sticky, oBit_count frame progress.
// Build option: define XOR_DECRYPT_CHECKSUM_EN to add oChecksum (XOR of all plaintext bytes of the frame).
module xor_stream_decrypt
    import xor_cipher_pkg::*;
#(
    parameter int KEY_SIZE   = KEY_SIZE_DEF,
    parameter int MSG_SIZE   = MSG_SIZE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           iClk,
    input  logic                           iRst_n,
    input  logic                           iEn,
    input  logic [KEY_SIZE-1:0]            iKey,
    input  logic                           iKey_load,
    input  logic                           iSerial_in,
    input  logic                           iSerial_start,
    input  logic                           iSerial_end,
    output logic [7:0]                     oData,
    output logic                           oData_valid,
    input  logic                           iData_ready,
    output logic                           oFrame_done,
    output logic                           oFrame_err,
    output logic                           oOverflow,
`ifdef XOR_DECRYPT_CHECKSUM_EN
    output logic [7:0]                     oChecksum,
`endif
    output logic [bit_cnt_w(MSG_SIZE)-1:0] oBit_count
);

    localparam int BCW = bit_cnt_w(MSG_SIZE);
    localparam int KIW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;

    xor_state_e          state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [KIW-1:0]      key_idx_q, key_idx_d;
    logic [7:0]          sr_q, sr_d;
    logic                wr_vld_q, wr_vld_d;
    logic [7:0]          wr_dat_q, wr_dat_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;
`ifdef XOR_DECRYPT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                cap;        // capture iSerial_in this cycle
    logic                first;      // captured bit is frame bit 0
    logic                keep_byte;  // a byte completed by this bit goes to the FIFO
    logic [KEY_SIZE-1:0] key_cur;
    logic [2:0]          pos;
    logic [KIW-1:0]      kidx;
    logic                pt_bit;
    logic [7:0]          byte_nxt;

    logic                fifo_push;
    logic                fifo_drop;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        bit_cnt_d = bit_cnt_q;
        key_idx_d = key_idx_q;
        sr_d      = sr_q;
        wr_vld_d  = wr_vld_q;
        wr_dat_d  = wr_dat_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ovf_d     = ovf_q | fifo_drop;
`ifdef XOR_DECRYPT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        cap       = 1'b0;
        first     = 1'b0;
        keep_byte = 1'b1;
        key_cur   = key_q;
        pos       = 3'd0;
        kidx      = '0;
        pt_bit    = 1'b0;
        byte_nxt  = sr_q;

        if (iEn) begin
            // Any pending byte is pushed on this edge, so the stage empties unless refilled below.
            wr_vld_d = 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        // The last byte leaves the write stage on this edge.
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    if (iKey_load) begin
                        key_d   = iKey;
                        // A frame starting in the same cycle already uses the new key for bit 0.
                        key_cur = iKey;
                        ovf_d   = 1'b0;
                    end
                    if (iSerial_start && iSerial_end) begin
                        err_d = 1'b1;
                    end else if (iSerial_start) begin
                        cap     = 1'b1;
                        first   = 1'b1;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (iSerial_start) begin
                        err_d = 1'b1;
                        cap   = 1'b1;
                        first = 1'b1;
                    end else if (iSerial_end) begin
                        if (bit_cnt_q == BCW'(MSG_SIZE - 1)) begin
                            cap     = 1'b1;
                            state_d = DONE;
                        end else begin
                            // Short frame: the partial byte in sr_q is simply abandoned.
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        cap = 1'b1;
                        if (bit_cnt_q == BCW'(MSG_SIZE - 1)) begin
                            // Frame ran to full length without its end marker.
                            err_d     = 1'b1;
                            keep_byte = 1'b0;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (cap) begin
                pos            = first ? 3'd0 : bit_cnt_q[2:0];
                kidx           = first ? '0 : key_idx_q;
                pt_bit         = iSerial_in ^ key_cur[kidx];
                byte_nxt       = first ? 8'h00 : sr_q;
                byte_nxt[pos]  = pt_bit;
                sr_d           = byte_nxt;
                bit_cnt_d      = first ? BCW'(1) : bit_cnt_q + 1'b1;
                key_idx_d      = (kidx == KIW'(KEY_SIZE - 1)) ? '0 : kidx + 1'b1;
`ifdef XOR_DECRYPT_CHECKSUM_EN
                if (first) begin
                    csum_d = 8'h00;
                end
`endif
                if ((pos == 3'd7) && keep_byte) begin
                    wr_vld_d = 1'b1;
                    wr_dat_d = byte_nxt;
`ifdef XOR_DECRYPT_CHECKSUM_EN
                    csum_d   = csum_q ^ byte_nxt;
`endif
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            bit_cnt_q <= '0;
            key_idx_q <= '0;
            sr_q      <= 8'h00;
            wr_vld_q  <= 1'b0;
            wr_dat_q  <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef XOR_DECRYPT_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            bit_cnt_q <= bit_cnt_d;
            key_idx_q <= key_idx_d;
            sr_q      <= sr_d;
            wr_vld_q  <= wr_vld_d;
            wr_dat_q  <= wr_dat_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
`ifdef XOR_DECRYPT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // The write stage is frozen together with the rest of the receive path.
    assign fifo_push = wr_vld_q && iEn;

    xor_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (iClk),
        .arst_n   (iRst_n),
        .wr_vld   (fifo_push),
        .wr_dat   (wr_dat_q),
        .wr_drop  (fifo_drop),
        .rd_vld   (oData_valid),
        .rd_rdy   (iData_ready),
        .rd_dat   (oData)
    );

    assign oFrame_done = done_q;
    assign oFrame_err  = err_q;
    assign oOverflow   = ovf_q;
    assign oBit_count  = bit_cnt_q;
`ifdef XOR_DECRYPT_CHECKSUM_EN
    assign oChecksum   = csum_q;
`endif

endmodule

// File: tb/tb_xor_stream_decrypt.sv
`timescale 1ns/1ps
module tb_xor_stream_decrypt;

    localparam int KS  = 32;
    localparam int MS  = 512;
    localparam int FD  = 4;
    localparam int BCW = $clog2(MS) + 1;
    localparam int NB  = MS / 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic [KS-1:0] key;
    logic          key_load;
    logic          ser_in;
    logic          ser_start;
    logic          ser_end;
    logic [7:0]    dat;
    logic          dat_vld;
    logic          rdy;
    logic          done;
    logic          err;
    logic          ovf;
    logic [BCW-1:0] bcnt;
`ifdef XOR_DECRYPT_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    xor_stream_decrypt #(
        .KEY_SIZE   (KS),
        .MSG_SIZE   (MS),
        .FIFO_DEPTH (FD)
    ) dut (
        .iClk          (clk),
        .iRst_n        (rst_n),
        .iEn           (en),
        .iKey          (key),
        .iKey_load     (key_load),
        .iSerial_in    (ser_in),
        .iSerial_start (ser_start),
        .iSerial_end   (ser_end),
        .oData         (dat),
        .oData_valid   (dat_vld),
        .iData_ready   (rdy),
        .oFrame_done   (done),
        .oFrame_err    (err),
        .oOverflow     (ovf),
`ifdef XOR_DECRYPT_CHECKSUM_EN
        .oChecksum     (csum),
`endif
        .oBit_count    (bcnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation: bytes accepted by the consumer and pulse counts, sampled mid-cycle.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dat_vld && rdy) got_q.push_back(dat);
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    bit            en_rand  = 1'b0;
    bit            rdy_rand = 1'b0;
    logic          rdy_fixed = 1'b1;
    logic [KS-1:0] cur_key;
    logic [7:0]    exp_csum;

    // Reference: plaintext bit i = ct[i] ^ key[i % KS], byte k = bits 8k..8k+7 LSB first.
    function automatic logic [7:0] plain_byte(input logic [MS-1:0] ct, input logic [KS-1:0] k, input int idx);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = ct[8*idx + b] ^ k[(8*idx + b) % KS];
        return r;
    endfunction

    function automatic logic [MS-1:0] rand_ct();
        logic [MS-1:0] c;
        for (int w = 0; w < MS/32; w++) c[32*w +: 32] = $urandom;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy();
        rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    endtask

    task automatic drive_bit(input logic b, input logic s, input logic e);
        if (en_rand && ($urandom_range(0, 5) == 0)) begin
            en        = 1'b0;
            ser_in    = 1'($urandom);
            ser_start = 1'($urandom);
            ser_end   = 1'($urandom);
            set_rdy();
            step();
        end
        en        = 1'b1;
        ser_in    = b;
        ser_start = s;
        ser_end   = e;
        set_rdy();
        step();
        ser_start = 1'b0;
        ser_end   = 1'b0;
    endtask

    task automatic load_key(input logic [KS-1:0] k);
        en       = 1'b1;
        key      = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        cur_key  = k;
    endtask

    task automatic send_full(input logic [MS-1:0] ct);
        exp_csum = 8'h00;
        for (int i = 0; i < MS; i++) drive_bit(ct[i], i == 0, i == MS-1);
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back(plain_byte(ct, cur_key, k));
            exp_csum ^= plain_byte(ct, cur_key, k);
        end
    endtask

    task automatic drain_cmp(input string tag);
        int guard;
        guard     = 0;
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        rdy       = 1'b1;
        en        = 1'b1;
        repeat (3) step();
        while (dat_vld && guard < 200) begin
            step();
            guard++;
        end
        check({tag, "_drain_timeout"}, guard >= 200, 0);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MS-1:0] ct;
        logic [MS-1:0] ct2;
        logic [KS-1:0] k2;
        int d0;
        int e0;

        rst_n = 1'b0; en = 1'b0; key = '0; key_load = 1'b0;
        ser_in = 1'b0; ser_start = 1'b0; ser_end = 1'b0; rdy = 1'b1;
        cur_key = '0;
        repeat (2) step();
        check("rst_data", dat, 0);
        check("rst_valid", dat_vld, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_bitcnt", bcnt, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();

        // Ciphertext equal to the repeating key decrypts to all zeros.
        load_key(32'hA5A5A5A5);
        d0 = done_cnt; e0 = err_cnt;
        send_full({16{32'hA5A5A5A5}});
        drain_cmp("zero_pt");
        check("zero_pt_done", done_cnt - d0, 1);
        check("zero_pt_err", err_cnt - e0, 0);
        check("zero_pt_bitcnt", bcnt, MS);

        // All-zero ciphertext yields the key bytes LSB first.
        load_key(32'h01234567);
        send_full('0);
`ifdef XOR_DECRYPT_CHECKSUM_EN
        check("key_pat_csum", csum, exp_csum);
`endif
        drain_cmp("key_pat");

        // Consumer stalled for a whole frame: FIFO keeps the first bytes and later ones are dropped.
        k2 = $urandom;
        load_key(k2);
        ct = rand_ct();
        rdy_fixed = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < MS; i++) begin
            drive_bit(ct[i], i == 0, i == MS-1);
            if (i == 7)  check("lat_before", dat_vld, 0);
            if (i == 8)  check("lat_after", dat_vld, 1);
            if (i == 39) check("ovf_at_byte4", ovf, 0);
            if (i == 40) check("ovf_at_byte5", ovf, 1);
        end
        repeat (3) step();
        check("stall_valid", dat_vld, 1);
        check("stall_ovf", ovf, 1);
        check("stall_done", done_cnt - d0, 1);
        for (int k = 0; k < FD; k++) exp_q.push_back(plain_byte(ct, cur_key, k));
        drain_cmp("stall");
        load_key(k2);
        check("ovf_cleared", ovf, 0);

        // Early end marker at bit 100.
        ct = rand_ct();
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i <= 100; i++) drive_bit(ct[i], i == 0, i == 100);
        check("early_end_pulse", err, 1);
        for (int i = 0; i < 16; i++) drive_bit(1'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) exp_q.push_back(plain_byte(ct, cur_key, k));
        drain_cmp("early_end");
        check("early_end_err", err_cnt - e0, 1);
        check("early_end_done", done_cnt - d0, 0);

        // Restart inside a frame at bit 40, then a full frame.
        ct  = rand_ct();
        ct2 = rand_ct();
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 40; i++) drive_bit(ct[i], i == 0, 1'b0);
        drive_bit(ct2[0], 1'b1, 1'b0);
        check("restart_err", err, 1);
        check("restart_bitcnt", bcnt, 1);
        for (int i = 1; i < MS; i++) drive_bit(ct2[i], 1'b0, i == MS-1);
        for (int k = 0; k < 5; k++) exp_q.push_back(plain_byte(ct, cur_key, k));
        for (int k = 0; k < NB; k++) exp_q.push_back(plain_byte(ct2, cur_key, k));
        drain_cmp("restart");
        check("restart_err_cnt", err_cnt - e0, 1);
        check("restart_done_cnt", done_cnt - d0, 1);

        // Asynchronous reset mid-frame with bytes waiting in the FIFO.
        ct = rand_ct();
        rdy_fixed = 1'b0;
        for (int i = 0; i < 300; i++) drive_bit(ct[i], i == 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", dat, 0);
        check("mid_rst_valid", dat_vld, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_bitcnt", bcnt, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_done", done, 0);
        step();
        #3;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        cur_key = '0;
        rdy_fixed = 1'b1;
        step();

        // Key register was cleared by reset: plaintext equals ciphertext.
        send_full(rand_ct());
        drain_cmp("post_rst_key0");

        // A key load during reception must not affect the frame in flight.
        load_key(32'hC3A51E77);
        ct = rand_ct();
        for (int i = 0; i < MS; i++) begin
            if (i == 100) begin
                key      = 32'h5A5A0F0F;
                key_load = 1'b1;
            end
            drive_bit(ct[i], i == 0, i == MS-1);
            key_load = 1'b0;
        end
        for (int k = 0; k < NB; k++) exp_q.push_back(plain_byte(ct, cur_key, k));
        drain_cmp("key_hold");

        // Randomized frames with enable gaps and a sporadically stalled consumer.
        for (int f = 0; f < 4; f++) begin
            load_key($urandom);
            d0 = done_cnt; e0 = err_cnt;
            en_rand  = 1'b1;
            rdy_rand = 1'b1;
            send_full(rand_ct());
            en_rand  = 1'b0;
`ifdef XOR_DECRYPT_CHECKSUM_EN
            repeat (3) step();
            check($sformatf("rnd%0d_csum", f), csum, exp_csum);
`endif
            drain_cmp($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d_done", f), done_cnt - d0, 1);
            check($sformatf("rnd%0d_err", f), err_cnt - e0, 0);
            check($sformatf("rnd%0d_ovf", f), ovf, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xor_stream_decrypt.md
Name: xor_stream_decrypt

Overview:
Receive-side counterpart of the serial XOR cipher output path. Takes the framed 1-bit ciphertext stream (data/start/end), XORs each bit with the repeating KEY_SIZE-bit key, and packs the plaintext into bytes. Bytes leave through a small FIFO with a valid/ready handshake. Sits on the host/test side of the link, or on-chip for loopback self-test.

Parameters:
KEY_SIZE, 32, key width in bits; the key repeats every KEY_SIZE stream bits.
MSG_SIZE, 512, frame length in bits; must be a multiple of 8.
FIFO_DEPTH, 4, output byte FIFO entries; power of two, at least 2.

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iEn  in  1  enable; when low, all state holds and serial inputs are ignored
iKey  in  KEY_SIZE  decryption key
iKey_load  in  1  latch iKey into the key register (IDLE/DONE only)
iSerial_in  in  1  ciphertext bit
iSerial_start  in  1  high together with frame bit 0
iSerial_end  in  1  high together with frame bit MSG_SIZE-1
oData  out  8  plaintext byte at the FIFO head
oData_valid  out  1  FIFO not empty
iData_ready  in  1  consumer accepts oData when oData_valid and iData_ready are both high
oFrame_done  out  1  1-cycle pulse after a good frame's last byte is written to the FIFO
oFrame_err  out  1  1-cycle pulse on a framing error
oOverflow  out  1  sticky; set when a byte is dropped because the FIFO is full; cleared by reset or iKey_load
oBit_count  out  $clog2(MSG_SIZE)+1  bits received in the current frame

Behaviour:
- Reset (async, iRst_n=0):
  - key register = 0, state = IDLE, FIFO empty.
  - oData=0, oData_valid=0, oFrame_done=0, oFrame_err=0, oOverflow=0, oBit_count=0.
- Stream protocol:
  - One bit per iClk cycle while iEn=1, LSB first; frame bit i is ciphertext[i].
  - No backpressure on the stream.
- Decryption: plaintext bit i = iSerial_in XOR key[i mod KEY_SIZE]. The key index wraps to 0 after KEY_SIZE-1.
- Byte packing:
  - Plaintext bit i lands in shift-register bit (i mod 8).
  - When bit (8k+7) is captured, the byte is written to the FIFO on the next edge.
  - Latency from last bit sampled to oData_valid: 2 cycles if the FIFO was empty.
- FSM:
  - IDLE: iSerial_start=1 → RECV, capture bit 0, oBit_count=1.
  - RECV: each enabled cycle captures one bit and increments oBit_count.
    - iSerial_end=1 with the bit-count-before-capture equal to MSG_SIZE-1 → capture the last bit, go to DONE.
    - iSerial_end=1 with any other count → oFrame_err, discard the partial byte, go to IDLE.
    - iSerial_start=1 in RECV → oFrame_err, restart the frame with this bit as bit 0 (stay in RECV, oBit_count=1).
    - Count reaches MSG_SIZE without end → oFrame_err, go to IDLE.
  - DONE: after the final byte is written, pulse oFrame_done and go to IDLE.
    - If iSerial_start is high in that same cycle, it is treated as a new frame (go to RECV).
  - iSerial_start and iSerial_end both high in IDLE → oFrame_err; no bytes produced (only valid when MSG_SIZE=1, which is disallowed).
- Key:
  - iKey_load is honoured only in IDLE/DONE and ignored in RECV.
  - The key in use for a frame is fixed at start.
- FIFO:
  - Simultaneous push and pop when full is legal; no overflow.
  - Push when full without a pop: the byte is dropped and oOverflow is set; the frame still completes.
  - Pop when empty: no effect.
  - oData holds the head byte and is 0 when empty.
- iEn=0: the FSM, counters and shift register freeze. The FIFO pop side stays active.
- Reset mid-frame: everything returns to reset values immediately; there is no partial output.

Optional Feature:
XOR_DECRYPT_CHECKSUM_EN
- Defined: adds output oChecksum[7:0], the XOR of all plaintext bytes in the frame.
  - Cleared at frame start.
  - Updated on each byte capture, including dropped bytes.
  - Held from the oFrame_done pulse until the next start.
  - Reset value 0.
- Undefined: port and logic are absent.

Decomposition:
- Shared package xor_cipher_pkg: KEY_SIZE/MSG_SIZE defaults, the bit-count width function, and the FSM state enum (IDLE, RECV, DONE), shared with the transmit-side serializer.
- One sub-module: xor_byte_fifo (parameterised depth, 8-bit, sync read/write, full/empty).

Test Plan:
- Key 0xA5A5A5A5, ciphertext = 512 bits of repeated key (plaintext 0), iData_ready=1 → 64 bytes of 0x00, then 1 oFrame_done, no err.
- Key 0x01234567, all-zero ciphertext → bytes 0x67,0x45,0x23,0x01 repeating ×16; checksum (macro on) = 0x00.
- iData_ready=0 throughout a full frame, FIFO_DEPTH=4 → oData_valid stays high, 4 bytes retained, oOverflow=1 after byte 5; iKey_load clears it.
- iSerial_end asserted at bit 100 → oFrame_err pulse, 12 bytes output, no oFrame_done, state IDLE.
- iSerial_start reasserted at bit 40 → oFrame_err, oBit_count=1, next full frame decrypts correctly.
- iRst_n pulsed low at bit 300 → all outputs 0 and FIFO empty asynchronously; iKey_load during RECV is ignored (verify by key switch mid-frame).
